// File: rtl/audio_mixer_seq.sv
// audio_mixer_seq: sequential N-channel stereo mixer.
// On a request it snapshots all channels, then accumulates one channel per clock
// (gain, floor-rounded rescale, L/R routing) and finally saturates the two sums
// to signed 16-bit outputs with sticky clip flags.
module audio_mixer_seq #(
    parameter int NUM_CH = 4,
    parameter int GAIN_W = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     sample_req_i,
    input  logic [NUM_CH*16-1:0]     ch_data_i,
    input  logic [NUM_CH*GAIN_W-1:0] ch_gain_i,
    input  logic [NUM_CH*2-1:0]      ch_route_i,
    input  logic                     clip_clr_i,
    output logic signed [15:0]       left_o,
    output logic signed [15:0]       right_o,
    output logic                     valid_o,
    output logic                     busy_o,
    output logic                     clip_l_o,
    output logic                     clip_r_o,
    output logic                     overrun_o
);
    // product of signed sample and zero-extended gain
    localparam int P_W   = 16 + GAIN_W + 1;
    // wide enough that NUM_CH worst-case terms never wrap
    localparam int ACC_W = 16 + GAIN_W + $clog2(NUM_CH) + 1;
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic signed [ACC_W-1:0] MAX_S = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] MIN_S = ACC_W'(-32768);

    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

    state_t                         state;
    logic [NUM_CH-1:0][15:0]        snap_data;
    logic [NUM_CH-1:0][GAIN_W-1:0]  snap_gain;
    logic [NUM_CH-1:0][1:0]         snap_route;
    logic [IDX_W-1:0]               idx;
    logic signed [ACC_W-1:0]        acc_l;
    logic signed [ACC_W-1:0]        acc_r;

    logic signed [15:0]             cur_data;
    logic signed [GAIN_W:0]         cur_gain;
    logic [1:0]                     cur_route;
    logic signed [P_W-1:0]          prod;
    logic signed [P_W-1:0]          prod_sh;
    logic signed [ACC_W-1:0]        term;

    // Current channel term: gain is unsigned, so it gets a zero sign bit;
    // the arithmetic shift rescales unity gain back to 1.0 with floor rounding.
    assign cur_data  = snap_data[idx];
    assign cur_gain  = {1'b0, snap_gain[idx]};
    assign cur_route = snap_route[idx];
    assign prod      = P_W'(cur_data) * P_W'(cur_gain);
    assign prod_sh   = prod >>> (GAIN_W - 1);
    assign term      = ACC_W'(prod_sh);

    function automatic logic [15:0] sat16(input logic signed [ACC_W-1:0] a);
        if (a > MAX_S)      return 16'h7fff;
        else if (a < MIN_S) return 16'h8000;
        else                return a[15:0];
    endfunction

    function automatic logic clipped(input logic signed [ACC_W-1:0] a);
        return (a > MAX_S) || (a < MIN_S);
    endfunction

    // Mix sequencer: snapshot, per-channel accumulate, saturate and publish.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            snap_data  <= '0;
            snap_gain  <= '0;
            snap_route <= '0;
            idx        <= '0;
            acc_l      <= '0;
            acc_r      <= '0;
            left_o     <= '0;
            right_o    <= '0;
            valid_o    <= 1'b0;
            busy_o     <= 1'b0;
            clip_l_o   <= 1'b0;
            clip_r_o   <= 1'b0;
            overrun_o  <= 1'b0;
        end else begin
            valid_o   <= 1'b0;
            // a request landing while busy is dropped and reported a cycle later
            overrun_o <= sample_req_i && busy_o;
            // clear first so a clip set later in this block takes priority
            if (clip_clr_i) begin
                clip_l_o <= 1'b0;
                clip_r_o <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (sample_req_i) begin
                        snap_data  <= ch_data_i;
                        snap_gain  <= ch_gain_i;
                        snap_route <= ch_route_i;
                        acc_l      <= '0;
                        acc_r      <= '0;
                        idx        <= '0;
                        busy_o     <= 1'b1;
                        state      <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (cur_route[0]) acc_l <= acc_l + term;
                    if (cur_route[1]) acc_r <= acc_r + term;
                    idx <= idx + IDX_W'(1);
                    if (idx == IDX_W'(NUM_CH - 1)) state <= OUT;
                end
                OUT: begin
                    left_o  <= sat16(acc_l);
                    right_o <= sat16(acc_r);
                    valid_o <= 1'b1;
                    busy_o  <= 1'b0;
                    if (clipped(acc_l)) clip_l_o <= 1'b1;
                    if (clipped(acc_r)) clip_r_o <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_mixer_seq.sv
// tb_audio_mixer_seq: directed vector table plus hand-written sequences for
// overrun, sticky clip flags and mid-mix reset of audio_mixer_seq (NUM_CH=4).
module tb_audio_mixer_seq;
    localparam int NUM_CH = 4;
    localparam int GAIN_W = 8;
    localparam int NVEC   = 10;

    logic                     clk_i = 1'b0;
    logic                     rst_i;
    logic                     sample_req_i;
    logic [NUM_CH*16-1:0]     ch_data_i;
    logic [NUM_CH*GAIN_W-1:0] ch_gain_i;
    logic [NUM_CH*2-1:0]      ch_route_i;
    logic                     clip_clr_i;
    logic signed [15:0]       left_o;
    logic signed [15:0]       right_o;
    logic                     valid_o;
    logic                     busy_o;
    logic                     clip_l_o;
    logic                     clip_r_o;
    logic                     overrun_o;

    audio_mixer_seq #(.NUM_CH(NUM_CH), .GAIN_W(GAIN_W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .sample_req_i (sample_req_i),
        .ch_data_i    (ch_data_i),
        .ch_gain_i    (ch_gain_i),
        .ch_route_i   (ch_route_i),
        .clip_clr_i   (clip_clr_i),
        .left_o       (left_o),
        .right_o      (right_o),
        .valid_o      (valid_o),
        .busy_o       (busy_o),
        .clip_l_o     (clip_l_o),
        .clip_r_o     (clip_r_o),
        .overrun_o    (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [63:0] data;
        logic [31:0] gain;
        logic [7:0]  route;
        int          el;
        int          er;
        logic        cl;
        logic        cr;
    } vec_t;

    vec_t vecs [NVEC];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [63:0] pk16(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic logic [31:0] pk8(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    // bit 0 of each pair = left, bit 1 = right
    function automatic logic [7:0] pkr(input int a, input int b, input int c, input int d);
        return {2'(d), 2'(c), 2'(b), 2'(a)};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Starts a mix in the current (negedge) cycle and checks latency and results.
    task automatic run_mix(input vec_t v, input string nm, input bit clr_hold);
        int lat;
        ch_data_i    = v.data;
        ch_gain_i    = v.gain;
        ch_route_i   = v.route;
        clip_clr_i   = clr_hold;
        sample_req_i = 1'b1;
        @(posedge clk_i); @(negedge clk_i);
        sample_req_i = 1'b0;
        chk({nm, "_busy_start"}, int'(busy_o), 1);
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk_i); @(negedge clk_i);
            if (valid_o) begin
                lat = k;
                break;
            end
        end
        clip_clr_i = 1'b0;
        chk({nm, "_latency"}, lat, 5);
        chk({nm, "_left"}, int'(left_o), v.el);
        chk({nm, "_right"}, int'(right_o), v.er);
        chk({nm, "_clip_l"}, int'(clip_l_o), int'(v.cl));
        chk({nm, "_clip_r"}, int'(clip_r_o), int'(v.cr));
        chk({nm, "_busy_end"}, int'(busy_o), 0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_left"},    int'(left_o), 0);
        chk({nm, "_right"},   int'(right_o), 0);
        chk({nm, "_valid"},   int'(valid_o), 0);
        chk({nm, "_busy"},    int'(busy_o), 0);
        chk({nm, "_clip_l"},  int'(clip_l_o), 0);
        chk({nm, "_clip_r"},  int'(clip_r_o), 0);
        chk({nm, "_overrun"}, int'(overrun_o), 0);
    endtask

    initial begin
        int n_valid;
        int n_ovr;
        int ovr_at2;
        int cap_l;
        int cap_r;
        int cap_cl;
        int cap_cr;
        vec_t s;

        // data a..d, gains a..d, routes a..d, expected L, R, clip_l, clip_r
        vecs[0] = '{pk16(1000, -2000, 3000, -4000), pk8(128, 128, 128, 128), pkr(1, 2, 1, 2), 4000, -6000, 1'b0, 1'b0};
        vecs[1] = '{pk16(20000, -2000, 20000, -4000), pk8(128, 128, 128, 128), pkr(1, 2, 1, 2), 32767, -6000, 1'b1, 1'b0};
        vecs[2] = '{pk16(1000, -20000, 1000, -20000), pk8(128, 128, 128, 128), pkr(1, 2, 1, 2), 2000, -32768, 1'b0, 1'b1};
        vecs[3] = '{pk16(-1, 5000, 5000, 5000), pk8(64, 0, 0, 0), pkr(1, 1, 1, 1), -1, 0, 1'b0, 1'b0};
        vecs[4] = '{pk16(-32768, 1, 1, 1), pk8(255, 0, 0, 0), pkr(1, 1, 1, 1), -32768, 0, 1'b1, 1'b0};
        vecs[5] = '{pk16(32767, -32768, 12345, -1), pk8(0, 0, 0, 0), pkr(3, 3, 3, 3), 0, 0, 1'b0, 1'b0};
        vecs[6] = '{pk16(100, 500, 500, 500), pk8(128, 0, 0, 0), pkr(3, 3, 3, 3), 100, 100, 1'b0, 1'b0};
        vecs[7] = '{pk16(100, 500, 500, 500), pk8(128, 128, 128, 128), pkr(0, 0, 0, 0), 0, 0, 1'b0, 1'b0};
        vecs[8] = '{pk16(3, -3, 0, 0), pk8(192, 192, 0, 0), pkr(1, 1, 0, 0), -1, 0, 1'b0, 1'b0};
        vecs[9] = '{pk16(32767, 32767, 32767, 32767), pk8(255, 255, 255, 255), pkr(3, 3, 3, 3), 32767, 32767, 1'b1, 1'b1};

        rst_i        = 1'b1;
        sample_req_i = 1'b0;
        ch_data_i    = '0;
        ch_gain_i    = '0;
        ch_route_i   = '0;
        clip_clr_i   = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk_all_zero("reset");
        rst_i = 1'b0;
        @(negedge clk_i);

        // Table: each mix starts in the cycle the previous valid_o is high, and
        // clip_clr_i is held through the mix so the final edge sees clear + set.
        for (int i = 0; i < NVEC; i++)
            run_mix(vecs[i], $sformatf("v%0d", i), 1'b1);

        // Overrun: second request at E2 is dropped; data change at E1 is ignored.
        // Flags from v9 must survive this non-clipping mix.
        ch_data_i    = vecs[0].data;
        ch_gain_i    = vecs[0].gain;
        ch_route_i   = vecs[0].route;
        sample_req_i = 1'b1;
        n_valid = 0; n_ovr = 0; ovr_at2 = 0;
        cap_l = 0; cap_r = 0; cap_cl = 0; cap_cr = 0;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk_i); @(negedge clk_i);
            if (valid_o) begin
                n_valid++;
                if (c == 5) begin
                    cap_l  = int'(left_o);
                    cap_r  = int'(right_o);
                    cap_cl = int'(clip_l_o);
                    cap_cr = int'(clip_r_o);
                end
            end
            if (overrun_o) begin
                n_ovr++;
                if (c == 2) ovr_at2 = 1;
            end
            sample_req_i = (c == 1);
            if (c == 0) ch_data_i = pk16(7777, 7777, -7777, 7777);
        end
        chk("ovr_valid_count", n_valid, 1);
        chk("ovr_overrun_count", n_ovr, 1);
        chk("ovr_overrun_timing", ovr_at2, 1);
        chk("ovr_left", cap_l, 4000);
        chk("ovr_right", cap_r, -6000);
        chk("sticky_clip_l", cap_cl, 1);
        chk("sticky_clip_r", cap_cr, 1);

        // Standalone clear pulse drops both flags.
        clip_clr_i = 1'b1;
        @(posedge clk_i); @(negedge clk_i);
        clip_clr_i = 1'b0;
        chk("clr_clip_l", int'(clip_l_o), 0);
        chk("clr_clip_r", int'(clip_r_o), 0);

        // Leave non-zero outputs behind before the reset test.
        run_mix(vecs[1], "pre_rst", 1'b0);

        // Reset at E2 aborts the mix.
        ch_data_i    = vecs[0].data;
        ch_gain_i    = vecs[0].gain;
        ch_route_i   = vecs[0].route;
        sample_req_i = 1'b1;
        @(posedge clk_i); @(negedge clk_i);
        sample_req_i = 1'b0;
        @(posedge clk_i); @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i); @(negedge clk_i);
        rst_i = 1'b0;
        chk_all_zero("midrst");
        n_valid = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk_i); @(negedge clk_i);
            if (valid_o) n_valid++;
        end
        chk("midrst_no_valid", n_valid, 0);

        s = vecs[0];
        run_mix(s, "post_rst", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
